// File: rtl/sal_cmd_encoder_mr.sv
// DDR command encoder: takes one decoded scheduler command per valid/ready handshake and
// drives the registered DFI control bus from the DDR command truth table.
// Supports NUM_RANKS chip selects, runtime 1T/2T command timing, and per-rank write ODT windows.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   mode_2t           0 = 1T, 1 = 2T; sampled at each handshake
//   cmd_valid/ready   command handshake (ready depends only on state)
//   cmd_type          0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 MRS
//   cmd_rank/ba/ra/ca/ap/mr  command fields
//   dfi_*             registered DFI control bus
//   cmd_issued        high in every cycle where some cs_n is low
module sal_cmd_encoder_mr #(
  parameter int unsigned NUM_RANKS = 2,
  parameter int unsigned BA_W      = 3,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned CA_W      = 10,
  parameter int unsigned ODT_CYC   = 6,
  localparam int unsigned RK_W     = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_2t,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_type,
  input  logic [RK_W-1:0]      cmd_rank,
  input  logic [BA_W-1:0]      cmd_ba,
  input  logic [ADDR_W-1:0]    cmd_ra,
  input  logic [CA_W-1:0]      cmd_ca,
  input  logic                 cmd_ap,
  input  logic [ADDR_W-1:0]    cmd_mr,
  output logic [NUM_RANKS-1:0] dfi_cke,
  output logic [NUM_RANKS-1:0] dfi_cs_n,
  output logic                 dfi_ras_n,
  output logic                 dfi_cas_n,
  output logic                 dfi_we_n,
  output logic [BA_W-1:0]      dfi_ba,
  output logic [ADDR_W-1:0]    dfi_addr,
  output logic [NUM_RANKS-1:0] dfi_odt,
  output logic                 cmd_issued
);

  localparam logic [1:0] StInit  = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StSetup = 2'd2;
  localparam logic [1:0] StIssue = 2'd3;

  localparam logic [2:0] CmdNop  = 3'd0;
  localparam logic [2:0] CmdAct  = 3'd1;
  localparam logic [2:0] CmdRd   = 3'd2;
  localparam logic [2:0] CmdWr   = 3'd3;
  localparam logic [2:0] CmdPre  = 3'd4;
  localparam logic [2:0] CmdPrea = 3'd5;
  localparam logic [2:0] CmdRef  = 3'd6;
  localparam logic [2:0] CmdMrs  = 3'd7;

  localparam logic [3:0] OdtLoad = 4'(ODT_CYC);

  logic [1:0]           state_q, state_d;
  logic [NUM_RANKS-1:0] pend_cs_n_q, pend_cs_n_d;
  logic                 pend_wr_q, pend_wr_d;
  logic [NUM_RANKS-1:0] cke_d, cs_n_d;
  logic                 ras_d, cas_d, we_d, wr_d;
  logic [BA_W-1:0]      ba_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [NUM_RANKS-1:0][3:0] odt_cnt_q, odt_cnt_d;

  // Encoded view of the command currently offered on the input side.
  logic [NUM_RANKS-1:0] enc_cs_n;
  logic [2:0]           enc_rcw;
  logic [BA_W-1:0]      enc_ba;
  logic [ADDR_W-1:0]    enc_addr;
  logic                 enc_wr;
  logic                 hs;

  assign cmd_ready = (state_q == StIdle) || (state_q == StIssue);
  assign hs        = cmd_valid && cmd_ready;

  always_comb begin
    enc_cs_n = '1;
    enc_rcw  = 3'b111;
    enc_ba   = '0;
    enc_addr = '0;
    enc_wr   = 1'b0;
    // Out-of-range ranks match no lane, leaving cs_n all high: the command is dropped.
    for (int unsigned r = 0; r < NUM_RANKS; r++) begin
      if (32'(cmd_rank) == r) enc_cs_n[r] = 1'b0;
    end
    case (cmd_type)
      CmdNop:  enc_rcw = 3'b111;
      CmdAct:  begin enc_rcw = 3'b011; enc_ba = cmd_ba; enc_addr = cmd_ra; end
      CmdRd, CmdWr: begin
        enc_rcw              = (cmd_type == CmdWr) ? 3'b100 : 3'b101;
        enc_ba               = cmd_ba;
        enc_addr[10]         = cmd_ap;
        enc_addr[CA_W-1:0]   = cmd_ca;
        enc_wr               = (cmd_type == CmdWr);
      end
      CmdPre:  begin enc_rcw = 3'b010; enc_ba = cmd_ba; end
      CmdPrea: begin enc_rcw = 3'b010; enc_addr[10] = 1'b1; end
      CmdRef:  enc_rcw = 3'b001;
      CmdMrs:  begin enc_rcw = 3'b000; enc_ba = cmd_ba; enc_addr = cmd_mr; end
      default: enc_rcw = 3'b111;
    endcase
    if (&enc_cs_n) begin
      enc_rcw  = 3'b111;
      enc_ba   = '0;
      enc_addr = '0;
      enc_wr   = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_cs_n_d = pend_cs_n_q;
    pend_wr_d   = pend_wr_q;
    cke_d       = dfi_cke;
    cs_n_d      = '1;
    {ras_d, cas_d, we_d} = 3'b111;
    ba_d        = '0;
    addr_d      = '0;
    wr_d        = 1'b0;
    case (state_q)
      StInit: begin
        state_d = StIdle;
        cke_d   = '1;
      end
      StIdle, StIssue: begin
        if (hs) begin
          {ras_d, cas_d, we_d} = enc_rcw;
          ba_d   = enc_ba;
          addr_d = enc_addr;
          if (mode_2t) begin
            state_d     = StSetup;
            pend_cs_n_d = enc_cs_n;
            pend_wr_d   = enc_wr;
          end else begin
            state_d = StIssue;
            cs_n_d  = enc_cs_n;
            wr_d    = enc_wr;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StSetup: begin
        // Hold the setup-cycle bus and add the chip select.
        state_d = StIssue;
        {ras_d, cas_d, we_d} = {dfi_ras_n, dfi_cas_n, dfi_we_n};
        ba_d    = dfi_ba;
        addr_d  = dfi_addr;
        cs_n_d  = pend_cs_n_q;
        wr_d    = pend_wr_q;
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_RANKS; r++) begin
      if (wr_d && !cs_n_d[r]) begin
        odt_cnt_d[r] = OdtLoad;
      end else if (odt_cnt_q[r] != 4'd0) begin
        odt_cnt_d[r] = odt_cnt_q[r] - 4'd1;
      end else begin
        odt_cnt_d[r] = 4'd0;
      end
      dfi_odt[r] = (odt_cnt_q[r] != 4'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      pend_cs_n_q <= '1;
      pend_wr_q   <= 1'b0;
      dfi_cke     <= '0;
      dfi_cs_n    <= '1;
      dfi_ras_n   <= 1'b1;
      dfi_cas_n   <= 1'b1;
      dfi_we_n    <= 1'b1;
      dfi_ba      <= '0;
      dfi_addr    <= '0;
      cmd_issued  <= 1'b0;
      odt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_cs_n_q <= pend_cs_n_d;
      pend_wr_q   <= pend_wr_d;
      dfi_cke     <= cke_d;
      dfi_cs_n    <= cs_n_d;
      dfi_ras_n   <= ras_d;
      dfi_cas_n   <= cas_d;
      dfi_we_n    <= we_d;
      dfi_ba      <= ba_d;
      dfi_addr    <= addr_d;
      cmd_issued  <= ~&cs_n_d;
      odt_cnt_q   <= odt_cnt_d;
    end
  end

endmodule

// File: tb/tb_sal_cmd_encoder_mr.sv
// Self-checking bench for sal_cmd_encoder_mr (default parameters). Expected bus words are
// hand-written and queued as commands are offered; a monitor pops one per cmd_issued cycle.
module tb_sal_cmd_encoder_mr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_2t = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_type = '0;
  logic [0:0]  cmd_rank = '0;
  logic [2:0]  cmd_ba = '0;
  logic [15:0] cmd_ra = '0;
  logic [9:0]  cmd_ca = '0;
  logic        cmd_ap = 1'b0;
  logic [15:0] cmd_mr = '0;
  logic [1:0]  dfi_cke, dfi_cs_n, dfi_odt;
  logic        dfi_ras_n, dfi_cas_n, dfi_we_n, cmd_issued;
  logic [2:0]  dfi_ba;
  logic [15:0] dfi_addr;

  int checks = 0;
  int failures = 0;
  // {cs_n[1:0], ras/cas/we, ba[2:0], addr[15:0]}
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp, mon_got;

  sal_cmd_encoder_mr dut (
    .clk(clk), .rst(rst), .mode_2t(mode_2t), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_rank(cmd_rank), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
    .cmd_ca(cmd_ca), .cmd_ap(cmd_ap), .cmd_mr(cmd_mr), .dfi_cke(dfi_cke),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .dfi_ba(dfi_ba), .dfi_addr(dfi_addr), .dfi_odt(dfi_odt), .cmd_issued(cmd_issued)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  // Scoreboard monitor: every issued command must match the oldest queued expectation.
  always @(negedge clk) begin
    if (cmd_issued === 1'b1) begin
      checks++;
      mon_got = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_issue got=%h exp=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL sb_cmd got=%h exp=%h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic rk, input logic [2:0] ba,
                       input logic [15:0] ra, input logic [9:0] ca, input logic ap,
                       input logic [15:0] mr);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_rank  = rk;
    cmd_ba    = ba;
    cmd_ra    = ra;
    cmd_ca    = ca;
    cmd_ap    = ap;
    cmd_mr    = mr;
  endtask

  task automatic expect_cmd(input logic [1:0] cs, input logic [2:0] rcw, input logic [2:0] ba,
                            input logic [15:0] a);
    exp_q.push_back({cs, rcw, ba, a});
  endtask

  task automatic chk_deselect(input string name);
    chk({name, "_cs_n"}, 32'(dfi_cs_n), 32'h3);
    chk({name, "_rcw"}, 32'({dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'h7);
    chk({name, "_addr"}, 32'(dfi_addr), 32'h0);
    chk({name, "_issued"}, 32'(cmd_issued), 32'h0);
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_cke", 32'(dfi_cke), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    chk("rst_odt", 32'(dfi_odt), 32'h0);
    chk("rst_ba", 32'(dfi_ba), 32'h0);
    chk_deselect("rst");

    rst = 1'b0;
    #1;
    chk("init_ready", 32'(cmd_ready), 32'h0);
    chk("init_cke", 32'(dfi_cke), 32'h0);
    cyc();
    chk("idle_cke", 32'(dfi_cke), 32'h3);
    chk("idle_ready", 32'(cmd_ready), 32'h1);
    chk_deselect("idle");

    // 1T back-to-back ACT then RD with auto-precharge
    drive(3'd1, 1'b1, 3'd3, 16'h1234, 10'h000, 1'b0, 16'h0);
    expect_cmd(2'b01, 3'b011, 3'd3, 16'h1234);
    cyc();
    chk("b2b_ready", 32'(cmd_ready), 32'h1);
    chk("b2b_act_cs", 32'(dfi_cs_n), 32'h1);
    drive(3'd2, 1'b1, 3'd3, 16'hFFFF, 10'h02A, 1'b1, 16'h0);
    expect_cmd(2'b01, 3'b101, 3'd3, 16'h042A);
    cyc();
    chk("b2b_rd_issued", 32'(cmd_issued), 32'h1);
    cmd_valid = 1'b0;
    cyc();
    chk_deselect("after_b2b");

    // 2T WR rank0; mode flip during SETUP must not shorten it
    mode_2t = 1'b1;
    drive(3'd3, 1'b0, 3'd2, 16'h0, 10'h010, 1'b0, 16'h0);
    expect_cmd(2'b10, 3'b100, 3'd2, 16'h0010);
    cyc();
    cmd_valid = 1'b0;
    mode_2t = 1'b0;
    chk("setup_cs_n", 32'(dfi_cs_n), 32'h3);
    chk("setup_rcw", 32'({dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'h4);
    chk("setup_ba", 32'(dfi_ba), 32'h2);
    chk("setup_addr", 32'(dfi_addr), 32'h0010);
    chk("setup_ready", 32'(cmd_ready), 32'h0);
    chk("setup_issued", 32'(cmd_issued), 32'h0);
    cyc();
    chk("2t_issue_cs_n", 32'(dfi_cs_n), 32'h2);
    chk("2t_issue_ready", 32'(cmd_ready), 32'h1);
    chk("2t_issue_addr", 32'(dfi_addr), 32'h0010);
    repeat (7) cyc();
    chk("odt_drained", 32'(dfi_odt), 32'h0);

    // ODT: WR rank0 at T and T+3 -> odt[0] high T..T+8
    drive(3'd3, 1'b0, 3'd1, 16'h0, 10'h001, 1'b0, 16'h0);
    expect_cmd(2'b10, 3'b100, 3'd1, 16'h0001);
    cyc();
    cmd_valid = 1'b0;
    chk("odt_t0", 32'(dfi_odt), 32'h1);
    cyc();
    chk("odt_t1", 32'(dfi_odt), 32'h1);
    cyc();
    chk("odt_t2", 32'(dfi_odt), 32'h1);
    drive(3'd3, 1'b0, 3'd1, 16'h0, 10'h002, 1'b0, 16'h0);
    expect_cmd(2'b10, 3'b100, 3'd1, 16'h0002);
    cyc();
    cmd_valid = 1'b0;
    chk("odt_t3", 32'(dfi_odt), 32'h1);
    for (int k = 4; k <= 8; k++) begin
      cyc();
      chk($sformatf("odt_t%0d", k), 32'(dfi_odt), 32'h1);
    end
    cyc();
    chk("odt_t9", 32'(dfi_odt), 32'h0);

    // PREA / MRS / REF / PRE / NOP, 1T back-to-back
    drive(3'd5, 1'b0, 3'd5, 16'hABCD, 10'h3FF, 1'b0, 16'h0);
    expect_cmd(2'b10, 3'b010, 3'd0, 16'h0400);
    cyc();
    drive(3'd7, 1'b1, 3'd1, 16'h0, 10'h0, 1'b0, 16'h0B50);
    expect_cmd(2'b01, 3'b000, 3'd1, 16'h0B50);
    cyc();
    drive(3'd6, 1'b0, 3'd6, 16'h5555, 10'h155, 1'b1, 16'h0);
    expect_cmd(2'b10, 3'b001, 3'd0, 16'h0000);
    cyc();
    drive(3'd4, 1'b1, 3'd4, 16'hFFFF, 10'h0, 1'b1, 16'h0);
    expect_cmd(2'b01, 3'b010, 3'd4, 16'h0000);
    cyc();
    drive(3'd0, 1'b0, 3'd7, 16'h1111, 10'h111, 1'b1, 16'h2222);
    expect_cmd(2'b10, 3'b111, 3'd0, 16'h0000);
    cyc();
    cmd_valid = 1'b0;
    chk("misc_odt", 32'(dfi_odt), 32'h0);
    cyc();
    chk_deselect("after_misc");

    // Reset during SETUP: pending ACT must never issue
    mode_2t = 1'b1;
    drive(3'd1, 1'b0, 3'd2, 16'h0F0F, 10'h0, 1'b0, 16'h0);
    cyc();
    cmd_valid = 1'b0;
    chk("rs_setup_ready", 32'(cmd_ready), 32'h0);
    chk("rs_setup_addr", 32'(dfi_addr), 32'h0F0F);
    rst = 1'b1;
    #1;
    chk("rs_cke", 32'(dfi_cke), 32'h0);
    chk("rs_ba", 32'(dfi_ba), 32'h0);
    chk_deselect("rs_async");
    cyc();
    chk("rs_held_cs_n", 32'(dfi_cs_n), 32'h3);
    rst = 1'b0;
    mode_2t = 1'b0;
    cyc();
    chk_deselect("rs_post1");
    cyc();
    chk_deselect("rs_post2");
    chk("rs_post_cke", 32'(dfi_cke), 32'h3);

    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sal_cmd_encoder_mr.md
# sal_cmd_encoder_mr

Parametrised DDR command encoder sitting between the scheduler and the DFI control interface: accepts one decoded command per valid/ready handshake and drives the registered DFI control bus per the DDR command truth table. Generalises single-rank, fixed-1T encoding to NUM_RANKS chip selects, adds a runtime 1T/2T command-timing mode, MRS and all-bank precharge, per-rank write ODT windows, and deterministic (non-X) deselect values.

## Interface
- NUM_RANKS, 2, number of chip selects / CKE / ODT lanes (1..4)
- BA_W, 3, bank address width
- ADDR_W, 16, DFI address width; row address width equals ADDR_W
- CA_W, 10, column address width (CA_W ≤ 10)
- ODT_CYC, 6, cycles dfi_odt[r] stays high after a WR to rank r (1..15)
- RK_W, $clog2(NUM_RANKS) (min 1), derived, not overridable
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- mode_2t  in  1  0 = 1T, 1 = 2T command timing; latched at each handshake
- cmd_valid  in  1  command present
- cmd_ready  out  1  encoder can accept (combinational from state)
- cmd_type  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 MRS
- cmd_rank  in  RK_W  target rank
- cmd_ba  in  BA_W  bank / MR select
- cmd_ra  in  ADDR_W  row address (ACT)
- cmd_ca  in  CA_W  column address (RD/WR)
- cmd_ap  in  1  auto-precharge (RD/WR)
- cmd_mr  in  ADDR_W  MRS opcode
- dfi_cke  out  NUM_RANKS  clock enable
- dfi_cs_n  out  NUM_RANKS  chip selects, active-low
- dfi_ras_n / dfi_cas_n / dfi_we_n  out  1 each  command pins
- dfi_ba  out  BA_W  bank address
- dfi_addr  out  ADDR_W  address
- dfi_odt  out  NUM_RANKS  on-die termination
- cmd_issued  out  1  one-cycle pulse in the cycle cs_n is driven low

## Operation
- Truth table (ras/cas/we): ACT 0/1/1, RD 1/0/1, WR 1/0/0, PRE and PREA 0/1/0, REF 0/0/1, MRS 0/0/0, NOP 1/1/1 (cs_n low).
- dfi_ba: cmd_ba for ACT/RD/WR/PRE/MRS; 0 for PREA/REF/NOP.
- dfi_addr: ACT = cmd_ra; RD/WR = {0…, cmd_ap at bit 10, zero-extended cmd_ca in [9:0]}; PRE = bit10 0, rest 0; PREA = bit10 1, rest 0; MRS = cmd_mr; REF/NOP = 0.
- Deselect (no command on bus): cs_n all 1, ras/cas/we 1, ba 0, addr 0.
- cmd_rank ≥ NUM_RANKS: handshake completes, command dropped, bus stays deselect, cmd_issued 0, no ODT effect.
- FSM states: INIT, IDLE, SETUP, ISSUE.
  - INIT: first cycle after reset release; cmd_ready 0; → IDLE, dfi_cke all 1 from then on.
  - IDLE / ISSUE: cmd_ready 1. Handshake with 1T latched → ISSUE (bus drives command, cs_n[rank] 0). Handshake with 2T → SETUP. No handshake → IDLE (bus deselect).
  - SETUP: cmd_ready 0; bus drives ras/cas/we/ba/addr of the pending command, cs_n all 1; → ISSUE next cycle with identical bus and cs_n[rank] 0.
- ODT: per-rank 4-bit down-counter; loaded with ODT_CYC in the cycle a WR to that rank appears with cs_n low; decrements otherwise when nonzero; dfi_odt[r] = counter≠0 (registered with the command). WR while counting reloads. Other commands do not affect ODT.

## Timing
- Reset values: dfi_cke 0, dfi_cs_n all 1, ras/cas/we 1, ba 0, addr 0, dfi_odt 0, cmd_issued 0, state INIT, ODT counters 0.
- rst asserted mid-command (SETUP or ISSUE): all outputs return to reset values asynchronously; pending command discarded, never issued.
- 1T latency: handshake at edge N → command on bus (cs_n low) during cycle N+1; sustained throughput 1 command/cycle.
- 2T latency: handshake at N → SETUP cycle N+1, cs_n low cycle N+2; throughput 1 command/2 cycles.
- mode_2t changes take effect only at the next handshake; a command already in SETUP completes in 2T.
- dfi_odt[r] high for exactly ODT_CYC cycles starting with the WR cs_n-low cycle.
- cmd_issued high exactly in cs_n-low cycles (including NOP), never in SETUP.

## Test plan
- Reset release: cycle 0 cmd_ready 0, cke 00; cycle 1 cke 11, cmd_ready 1, bus deselect (ras/cas/we 1, addr 0).
- 1T back-to-back: ACT rank1 ba3 ra 0x1234, then RD rank1 ba3 ca 0x2A ap1 -> cs_n 01 with 0/1/1 addr 0x1234, next cycle cs_n 01 with 1/0/1 addr 0x042A, cmd_issued 1,1.
- 2T: mode_2t 1, WR rank0 ba2 ca 0x10 -> cycle+1 cs_n 11, 1/0/0, ba2, addr 0x0010, cmd_ready 0; cycle+2 cs_n 10; cmd_ready 1.
- ODT: WR rank0 at cycle T, WR rank0 at T+3 (1T, ODT_CYC 6) -> dfi_odt[0] high T..T+8, low T+9; dfi_odt[1] stays 0.
- PREA/MRS/REF: PREA rank0 -> 0/1/0, ba 0, addr 0x0400; MRS ba1 mr 0x0B50 -> 0/0/0, ba1, addr 0x0B50; REF -> 0/0/1, addr 0.
- Reset in SETUP (2T ACT accepted, rst pulsed next cycle) -> cs_n never goes low, outputs at reset values, cmd_issued 0.
